// File: rtl/door_pkg.sv
// Shared types and defaults for the elevator door controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: door_state_e FSM encoding, default travel time and reopen limit.
package door_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } door_state_e;

  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_REOPEN_MAX  = 3;

endpackage

// File: rtl/door_move_timer.sv
// Door travel timer: loaded with the travel time, counts down once per moving cycle.
// Latency: done is high during the last cycle of a travel (count == 1).
// Backpressure: none; load has priority over dec, and the count holds at zero.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : reload MOVE_CYCLES on the next edge
//   dec        : count down by one on the next edge (no wrap below zero)
//   done       : current cycle is the final travel cycle
module door_move_timer
  import door_pkg::*;
#(
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int TW = $clog2(MOVE_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(MOVE_CYCLES);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == TW'(1));

endmodule

// File: rtl/door_controller.sv
// Elevator door controller: CLOSED -> OPENING -> OPEN (dwell) -> CLOSING, with obstruction reopen.
// Latency: outputs are registered and track the current state; input reactions appear one cycle later.
// Backpressure: hold_open/obstruct pause the dwell (door_wait low) and veto a coincident wait_complete.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   open_req                 : request a door cycle (ignored while opening)
//   hold_open, obstruct      : door-open button, door-edge sensor
//   wait_complete            : dwell-expired pulse from the external dwell counter
//   door_wait                : dwell counter enable
//   door_close, cycle_done   : one-cycle pulses at close start / cycle end
//   motor_open, motor_close  : motor drives, mutually exclusive
//   door_closed              : door fully shut
//   door_fault               : reopen limit exceeded, sticky until reset
// Optional feature macro: DOOR_FAULT_EN (reopen counting and fault parking).
module door_controller
  import door_pkg::*;
#(
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int REOPEN_MAX  = DEF_REOPEN_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic open_req,
  input  logic hold_open,
  input  logic obstruct,
  input  logic wait_complete,
  output logic door_wait,
  output logic door_close,
  output logic motor_open,
  output logic motor_close,
  output logic door_closed,
  output logic cycle_done,
  output logic door_fault
);

  if (MOVE_CYCLES < 1 || REOPEN_MAX < 1) begin : g_param_check
    $error("door_controller: MOVE_CYCLES and REOPEN_MAX must be >= 1");
  end

  door_state_e state_q, state_d;
  logic        tmr_load, tmr_dec, tmr_done;
  logic        door_wait_q, door_wait_d;
  logic        door_close_q, door_close_d;
  logic        motor_open_q, motor_open_d;
  logic        motor_close_q, motor_close_d;
  logic        door_closed_q, door_closed_d;
  logic        cycle_done_q, cycle_done_d;
  // parked: fault already latched; fault_nxt: fault as of the next cycle
  logic        parked, fault_nxt;

  door_move_timer #(
    .MOVE_CYCLES(MOVE_CYCLES)
  ) u_move_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .dec  (tmr_dec),
    .done (tmr_done)
  );

  assign tmr_dec = (state_q == ST_OPENING) || (state_q == ST_CLOSING);

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    door_close_d = 1'b0;
    cycle_done_d = 1'b0;
    case (state_q)
      ST_CLOSED: begin
        if (open_req) begin
          state_d  = ST_OPENING;
          tmr_load = 1'b1;
        end
      end
      ST_OPENING: begin
        if (tmr_done) begin
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        // A dwell expiry that coincides with hold/obstruct is dropped; the
        // dwell counter simply has to expire again once the door is clear.
        if (wait_complete && !hold_open && !obstruct && !parked) begin
          state_d      = ST_CLOSING;
          tmr_load     = 1'b1;
          door_close_d = 1'b1;
        end
      end
      ST_CLOSING: begin
        // Obstruction wins over open_req; either reopens with full travel.
        if (obstruct || open_req) begin
          state_d  = ST_OPENING;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d      = ST_CLOSED;
          cycle_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLOSED;
      end
    endcase

    door_closed_d = (state_d == ST_CLOSED);
    motor_open_d  = (state_d == ST_OPENING);
    motor_close_d = (state_d == ST_CLOSING);
    door_wait_d   = (state_d == ST_OPEN) && !hold_open && !obstruct && !fault_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_CLOSED;
      door_wait_q   <= 1'b0;
      door_close_q  <= 1'b0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      door_closed_q <= 1'b1;
      cycle_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      door_wait_q   <= door_wait_d;
      door_close_q  <= door_close_d;
      motor_open_q  <= motor_open_d;
      motor_close_q <= motor_close_d;
      door_closed_q <= door_closed_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

`ifdef DOOR_FAULT_EN
  localparam int RW = $clog2(REOPEN_MAX + 1);

  logic [RW-1:0] reopen_cnt_q, reopen_cnt_d;
  logic          door_fault_q, door_fault_d;

  always_comb begin
    reopen_cnt_d = reopen_cnt_q;
    door_fault_d = door_fault_q;
    if ((state_q == ST_CLOSING) && obstruct) begin
      // At the limit, one more obstruction latches the fault; the door still
      // travels open and then parks in OPEN.
      if (reopen_cnt_q == RW'(REOPEN_MAX)) begin
        door_fault_d = 1'b1;
      end else begin
        reopen_cnt_d = reopen_cnt_q + RW'(1);
      end
    end
    if (state_d == ST_CLOSED) begin
      reopen_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reopen_cnt_q <= '0;
      door_fault_q <= 1'b0;
    end else begin
      reopen_cnt_q <= reopen_cnt_d;
      door_fault_q <= door_fault_d;
    end
  end

  assign parked     = door_fault_q;
  assign fault_nxt  = door_fault_d;
  assign door_fault = door_fault_q;
`else
  assign parked     = 1'b0;
  assign fault_nxt  = 1'b0;
  assign door_fault = 1'b0;
`endif

  assign door_wait   = door_wait_q;
  assign door_close  = door_close_q;
  assign motor_open  = motor_open_q;
  assign motor_close = motor_close_q;
  assign door_closed = door_closed_q;
  assign cycle_done  = cycle_done_q;

endmodule
